// File: rtl/mon_prod_pkg.sv
// mon_prod_pkg: shared types and helpers for the bit-serial Montgomery multiplier.
package mon_prod_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned WORD_BITS = 8;

  // Effective iteration count k in bits. Zero or oversize word counts fall back
  // to the full operand width so the multiplier always does something sensible.
  function automatic int unsigned eff_k(input int unsigned nw, input int unsigned bit_len);
    int unsigned max_w;
    max_w = bit_len / WORD_BITS;
    if ((nw >= 1) && (nw <= max_w)) begin
      return WORD_BITS * nw;
    end
    return WORD_BITS * max_w;
  endfunction

endpackage

// File: rtl/mon_prod_step.sv
// mon_prod_step: one combinational radix-2 Montgomery iteration,
// T_next = (T + a*B + q*M) / 2 with q chosen so the sum is even.
// T carries two guard bits: T < 2M on entry keeps every partial sum below 4M.
module mon_prod_step #(
  parameter int W = 64
) (
  input  logic [W+1:0] i_t,
  input  logic         i_a_bit,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_m,
  output logic [W+1:0] o_t_next
);

  logic [W+1:0] w_sum_b;
  logic [W+1:0] w_sum_m;

  assign w_sum_b  = i_t + (i_a_bit ? {2'b00, i_b} : {(W+2){1'b0}});
  assign w_sum_m  = w_sum_b + (w_sum_b[0] ? {2'b00, i_m} : {(W+2){1'b0}});
  assign o_t_next = w_sum_m >> 1;

endmodule

// File: rtl/mon_prod.sv
// mon_prod: bit-serial Montgomery modular multiplier, P = A*B*2^-k mod M,
// k = 8 * effective word count. One iteration per clock, then one
// conditional-subtraction cycle, then a start/stop handshake in DONE.
// Optional build macro MON_PROD_BUSY_EN adds a 'busy' output (high in RUN/SUB).
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on start
//   RUN   | one radix-2 iteration per clock, i = 0 .. k-1
//   SUB   | final reduction T >= M ? T - M : T into P
//   DONE  | stop raised one cycle after entry; leave once stop seen and start low
module mon_prod
  import mon_prod_pkg::*;
#(
  parameter int bitLen     = 64,
  parameter int countWidth = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [bitLen-1:0]     A,
  input  logic [bitLen-1:0]     B,
  input  logic [bitLen-1:0]     M,
  input  logic [countWidth-1:0] num_words,
  output logic                  stop,
  output logic [bitLen:0]       P
`ifdef MON_PROD_BUSY_EN
  ,
  output logic                  busy
`endif
);

  localparam int IDX_W = (bitLen > 1) ? $clog2(bitLen) : 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [bitLen-1:0] r_a;
  logic [bitLen-1:0] r_b;
  logic [bitLen-1:0] r_m;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_i_last;
  logic [IDX_W-1:0]  w_i_last;
  logic [bitLen+1:0] r_t;
  logic [bitLen+1:0] w_t_step;
  logic [bitLen:0]   r_p;
  logic [bitLen:0]   w_diff;
  logic              r_stop;
  logic              w_last;
  logic              w_ge;
  logic              w_stop_ack;

  // Only the last iteration index is kept; k itself never needs storing.
  assign w_i_last   = IDX_W'(eff_k(32'(num_words), 32'(bitLen)) - 32'd1);
  assign w_last     = (r_i == r_i_last);
  assign w_ge       = (r_t >= {2'b00, r_m});
  // T < 2M, so when T >= M the difference fits in bitLen bits; the top guard bit
  // of T is not needed for the subtraction itself.
  assign w_diff     = r_t[bitLen:0] - {1'b0, r_m};
  assign w_stop_ack = r_stop & ~start;

  mon_prod_step #(
    .W(bitLen)
  ) u_step (
    .i_t      (r_t),
    .i_a_bit  (r_a[r_i]),
    .i_b      (r_b),
    .i_m      (r_m),
    .o_t_next (w_t_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE exits only after stop has been visible for a cycle
  // so a pulsed start still produces a stop pulse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)      w_state_next = RUN;
      RUN:     if (w_last)     w_state_next = SUB;
      SUB:                     w_state_next = DONE;
      DONE:    if (w_stop_ack) w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration accumulator, final reduction, stop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_i      <= '0;
      r_i_last <= '0;
      r_t      <= '0;
      r_p      <= '0;
      r_stop   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_m      <= M;
            r_i_last <= w_i_last;
            r_t      <= '0;
            r_i      <= '0;
          end
        end
        RUN: begin
          r_t <= w_t_step;
          r_i <= r_i + IDX_W'(1);
        end
        SUB: begin
          r_p <= w_ge ? w_diff : r_t[bitLen:0];
        end
        default: begin
        end
      endcase
      r_stop <= (r_state == DONE) && !w_stop_ack;
    end
  end

  assign stop = r_stop;
  assign P    = r_p;

`ifdef MON_PROD_BUSY_EN
  assign busy = (r_state == RUN) || (r_state == SUB);
`endif

endmodule

// File: tb/tb_mon_prod.sv
// tb_mon_prod: directed table plus randomized checks of mon_prod against a
// modular-arithmetic reference model (A*B*(2^-1)^k mod M).
module tb_mon_prod;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] M;
  logic [4:0]  num_words;
  logic        stop;
  logic [64:0] P;
`ifdef MON_PROD_BUSY_EN
  logic        busy;
`endif

  mon_prod #(
    .bitLen     (64),
    .countWidth (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .M         (M),
    .num_words (num_words),
    .stop      (stop),
    .P         (P)
`ifdef MON_PROD_BUSY_EN
    ,
    .busy      (busy)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] m;
    logic [4:0]  nw;
    logic [64:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int k_of(input logic [4:0] nw);
    if (nw >= 5'd1 && nw <= 5'd8) return 8 * int'(nw);
    return 64;
  endfunction

  // Montgomery product via ordinary modular arithmetic: 2^-1 mod M is (M+1)/2.
  function automatic logic [64:0] ref_mont(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] m, input int k);
    logic [127:0] x, h, mm;
    mm = {64'd0, m};
    x  = ({64'd0, a} * {64'd0, b}) % mm;
    h  = (mm + 128'd1) >> 1;
    for (int j = 0; j < k; j++) x = (x * h) % mm;
    return x[64:0];
  endfunction

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                              input logic [4:0] nw, input logic [64:0] p);
    vec_t v;
    v.a = a; v.b = b; v.m = m; v.nw = nw; v.exp_p = p; v.exp_lat = k_of(nw) + 2;
    return v;
  endfunction

  // Launch one operation; lat = edges after the start-sampling edge until stop, -1 on timeout.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                        input logic [4:0] nw, input bit scramble,
                        output logic [64:0] p, output int lat);
    @(negedge clk);
    A = a; B = b; M = m; num_words = nw; start = 1'b1;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 0 && scramble) begin
        A = {$urandom, $urandom}; B = {$urandom, $urandom};
        M = {$urandom, $urandom}; num_words = 5'($urandom);
      end
      if (stop) begin
        lat = n;
        break;
      end
    end
    p = P;
  endtask

  task automatic drop_start(input string name);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk(name, {127'd0, stop}, 128'd0);
  endtask

  logic [63:0] m64;
  logic [64:0] got_p;
  int          lat;

  initial begin
    m64 = 64'hFFFF_FFFF_FFFF_FFC5;
    vecs[0] = mk(64'd216, 64'd123, 64'd253, 5'd1, 65'd1);
    vecs[1] = mk(64'd1,   64'd1,   64'd253, 5'd1, 65'd169);
    vecs[2] = mk(64'd3,   64'd5,   64'd253, 5'd1, 65'd5);
    vecs[3] = mk(64'd0,   64'd200, 64'd253, 5'd1, 65'd0);
    vecs[4] = mk(64'd1,   64'd1,   m64,     5'd0,  ref_mont(64'd1, 64'd1, m64, 64));
    vecs[5] = mk(64'd1,   64'd1,   m64,     5'd31, ref_mont(64'd1, 64'd1, m64, 64));
    vecs[6] = mk(64'd12345, 64'd999, 64'd100003, 5'd3, ref_mont(64'd12345, 64'd999, 64'd100003, 24));

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; M = '0; num_words = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stop", {127'd0, stop}, 128'd0);
    chk("reset_p", {63'd0, P}, 128'd0);
`ifdef MON_PROD_BUSY_EN
    chk("reset_busy", {127'd0, busy}, 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].nw, 1'b0, got_p, lat);
      chk($sformatf("vec%0d_lat", v), 128'(lat), 128'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_p", v), {63'd0, got_p}, {63'd0, vecs[v].exp_p});
      if (v == 0) begin
        for (int h = 0; h < 3; h++) begin
          @(posedge clk);
          #1;
          chk("stop_hold", {127'd0, stop}, 128'd1);
        end
      end
      drop_start($sformatf("vec%0d_stop_fall", v));
    end

    // Reset during the fourth RUN cycle aborts the operation.
    @(negedge clk);
    A = 64'd216; B = 64'd123; M = 64'd253; num_words = 5'd1; start = 1'b1;
    repeat (4) @(posedge clk);
`ifdef MON_PROD_BUSY_EN
    #1;
    chk("busy_run", {127'd0, busy}, 128'd1);
`endif
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stop", {127'd0, stop}, 128'd0);
    chk("midrst_p", {63'd0, P}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_idle", {127'd0, stop}, 128'd0);
    run_op(64'd1, 64'd1, 64'd253, 5'd1, 1'b0, got_p, lat);
    chk("after_rst_lat", 128'(lat), 128'd10);
    chk("after_rst_p", {63'd0, got_p}, 128'd169);
    drop_start("after_rst_fall");

    for (int r = 0; r < 1000; r++) begin
      logic [4:0]  nw;
      logic [63:0] m, a, b;
      int          kk;
      nw = 5'($urandom_range(1, 8));
      kk = 8 * int'(nw);
      m  = {$urandom, $urandom};
      if (kk < 64) m = m & ((64'd1 << kk) - 64'd1);
      m[0] = 1'b1;
      if (m == 64'd1) m = 64'd3;
      a = {$urandom, $urandom} % m;
      b = {$urandom, $urandom} % m;
      run_op(a, b, m, nw, 1'b1, got_p, lat);
      chk($sformatf("rnd%0d_lat", r), 128'(lat), 128'(kk + 2));
      chk($sformatf("rnd%0d_p", r), {63'd0, got_p}, {63'd0, ref_mont(a, b, m, kk)});
      drop_start($sformatf("rnd%0d_fall", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mon_prod.md
Name: mon_prod

Overview:
- Bit-serial (radix-2) Montgomery modular multiplier: P = A·B·2^-k mod M, with k = 8·num_words bits.
- Building block for the RSA modular-exponentiation datapath; the exponentiator instantiates it and calls it repeatedly for squarings and multiplies.
- Start/stop handshake; one iteration per clock, followed by a final conditional-subtraction cycle.

Parameters:
- bitLen, 64, operand/modulus width in bits; must be a multiple of 8.
- countWidth, 5, width of num_words.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  level request; sampled only in IDLE.
- A  input  bitLen  multiplicand; requires A < M.
- B  input  bitLen  multiplier; requires B < M.
- M  input  bitLen  modulus; must be odd and > 1.
- num_words  input  countWidth  operand length in 8-bit words.
- stop  output  1  result valid / done.
- P  output  bitLen+1  result; fully reduced, so P < M.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous on rst_n low: state IDLE, stop=0, P=0, accumulator=0, counter=0. Reset mid-operation aborts the operation; no partial result is held.
- Effective word count w:
  - w = num_words if 1 ≤ num_words ≤ bitLen/8.
  - w = bitLen/8 otherwise, including 0 and oversize values.
  - k = 8·w.
- IDLE:
  - stop=0.
  - On start=1 at a rising edge: register A, B, M and k; clear accumulator T and bit counter i; go to RUN.
- RUN, one cycle per iteration, i = 0 .. k-1:
  - T ← T + A[i]·B.
  - If T is odd: T ← T + M.
  - T ← T >> 1.
  - i ← i + 1.
  - After the iteration with i = k-1, go to SUB.
- Width rule: T is held in bitLen+2 bits. The invariant T < 2M holds between iterations, and intermediate sums stay below 4M, so no overflow occurs.
- SUB (one cycle): P ← (T ≥ M) ? T − M : T; go to DONE.
- DONE:
  - stop=1; P holds.
  - Stays in DONE while start=1.
  - On start=0: go to IDLE and drop stop. P retains its last value until the next SUB or reset.
- Latency: start sampled at edge 0 → stop rises at edge k+2. With num_words=1 this is 10 clocks.
- Operand changes on A/B/M/num_words after start is sampled are ignored.
- M even or A/B ≥ M: the result is undefined, but the FSM still terminates at the normal latency.
- stop never asserts in the same cycle start is first sampled.

Optional Feature:
- Macro: MON_PROD_BUSY_EN.
- Defined:
  - Adds output port busy (1 bit), high in RUN and SUB, low in IDLE and DONE.
  - busy resets to 0.
- Undefined: the port is absent; all other behaviour is identical.

Decomposition:
- Package mon_prod_pkg:
  - State enum {IDLE, RUN, SUB, DONE}.
  - Constant WORD_BITS = 8.
  - Helper function for effective k from num_words.
- Sub-module mon_prod_step (combinational): one radix-2 iteration.
  - Inputs: T, a_bit, B, M.
  - Output: next T.

Test Plan:
- Reset and timing: rst_n=0 for 2 cycles, then A=216, B=123, M=253, num_words=1, start held 1 → stop rises exactly 10 clocks after start is sampled; P=1; stop stays 1 while start=1.
- Unit input: A=1, B=1, M=253, num_words=1 → P=169 (2^-8 mod 253).
- Montgomery form: A=3 (256 mod 253), B=5, M=253, num_words=1 → P=5. Also A=0, B=200, M=253 → P=0.
- Full width and clamping: num_words=0, A=1, B=1, M=2^64−59 → k=64, stop after 66 clocks, P = 2^-64 mod M (bench computes via reference model). Repeat with num_words=31 → identical result and latency.
- Reset mid-run: rst_n=0 at cycle 4 of RUN → next edge stop=0, P=0, state IDLE. A new start then completes normally with the correct result.
- Handshake: start dropped in DONE → stop falls next edge. Start reasserted with new operands → new result; random odd M vs software model across 1000 vectors, num_words 1..8.
